axi_rd_sched_2x1: RTL and testbench
===================================

AXI_RD_SCHED_2X1 -- requirements
Module: axi_rd_sched_2x1

Interface
REQ-001 The block SHALL have parameter ID_WIDTH, default 8, which is the width of the returned burst tag.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, which is the idle-handshake limit per burst; legal range is 2 to 65535.
REQ-003 The block SHALL have port clk, input, width 1: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, width 1: synchronous, active-high reset.
REQ-005 The block SHALL have port req, input, width 2: bit n is high while requester s0n has a read burst pending.
REQ-006 The block SHALL have port req_len, input, width 16: AXI arlen per requester, {s01[7:0], s00[7:0]}.
REQ-007 The block SHALL have port grant, output, width 2: one-hot selection of the requester that owns the master read port.
REQ-008 The block SHALL have port m_ar_hs, input, width 1: master arvalid&arready handshake.
REQ-009 The block SHALL have port m_r_hs, input, width 1: master rvalid&rready handshake.
REQ-010 The block SHALL have port m_r_last, input, width 1: master rlast, qualified by m_r_hs.
REQ-011 The block SHALL have port beats_left, output, width 9: remaining R beats of the current burst.
REQ-012 The block SHALL have port busy, output, width 1: high in ADDR or DATA.
REQ-013 The block SHALL have port done, output, width 1: one-cycle pulse on correct burst completion.
REQ-014 The block SHALL have port err, output, width 2: one-cycle pulse; bit0 = rlast mismatch, bit1 = timeout.

Function
REQ-015 The FSM SHALL have states IDLE, ADDR and DATA; grant SHALL be registered and equal 2'b00 in IDLE.
REQ-016 In IDLE with req!=0, the block SHALL move to ADDR next cycle with grant set; one-cycle request-to-grant latency.
REQ-017 Arbitration SHALL be round-robin: a sole requester wins; if both request, the one not granted last wins; after reset s00 wins first.
REQ-018 In ADDR, grant SHALL hold stable until m_ar_hs; on m_ar_hs, beats_left SHALL load req_len[granted]+1 (9-bit, 1 to 256) and the FSM SHALL enter DATA.
REQ-019 m_r_hs and m_r_last in IDLE or ADDR SHALL be ignored.
REQ-020 In DATA, each m_r_hs SHALL decrement beats_left by 1.
REQ-021 In DATA, m_r_hs with m_r_last and beats_left==1 SHALL pulse done, clear grant and return to IDLE.
REQ-022 In DATA, m_r_hs with m_r_last xor (beats_left==1) SHALL pulse err[0], clear grant, set beats_left to 0 and return to IDLE.
REQ-023 A 16-bit timeout counter SHALL clear on entry to ADDR and on every m_ar_hs/m_r_hs, and increment otherwise in ADDR/DATA.
REQ-024 When the timeout counter reaches TIMEOUT_CYCLES-1, the block SHALL pulse err[1] and return to IDLE.
REQ-025 If rlast-error and timeout occur in the same cycle, err[0] SHALL take priority and err[1] SHALL NOT assert.
REQ-026 A requester deasserting req after grant SHALL NOT revoke grant; the burst completes.
REQ-027 A new grant SHALL NOT issue in the same cycle as done; IDLE SHALL last at least one cycle.

Reset
REQ-028 rst SHALL force IDLE, grant=0, beats_left=0, busy=0, done=0, err=0, timeout counter=0 and round-robin pointer to "s01 last", including mid-burst.

Structure
REQ-029 Package axi_sched_pkg SHALL hold the state enum (IDLE=0, ADDR=1, DATA=2) and the err bit-index constants.
REQ-030 The arbitration decision SHALL live in sub-module rr_arb_2 (req[1:0], last pointer in, one-hot grant out; combinational).

Verification
REQ-031 Reset, req=2'b11 -> grant=2'b01 one cycle later; after completion, req still 2'b11 -> next grant=2'b10.
REQ-032 req_len[7:0]=3, m_ar_hs -> beats_left=4; four m_r_hs with last on the 4th -> done pulse, beats_left=0, busy=0.
REQ-033 req_len=0, single beat without m_r_last -> err=2'b01, IDLE next cycle.
REQ-034 TIMEOUT_CYCLES=8, grant issued, no m_ar_hs -> err=2'b10 on the 8th cycle in ADDR, grant cleared.
REQ-035 rst asserted in DATA with beats_left=5 -> next cycle all outputs 0; then req=2'b11 -> grant=2'b01.

Source files
------------

// File: rtl/axi_sched_pkg.sv
// Shared types for the 2:1 AXI read-burst scheduler: FSM state encoding and
// bit positions inside the err pulse vector.
package axi_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  localparam int ERR_RLAST   = 0;
  localparam int ERR_TIMEOUT = 1;

  // Turns an AXI arlen into a beat count (1..256).
  function automatic logic [8:0] beats_of(input logic [7:0] len);
    return {1'b0, len} + 9'd1;
  endfunction

endpackage

// File: rtl/axi_rd_sched_2x1_if.sv
// Bundle of the scheduler's requester/master-side signals. The master modport
// is the side that drives requests and master handshakes into the scheduler.
interface axi_rd_sched_2x1_if;
  logic [1:0]  req;
  logic [15:0] req_len;
  logic [1:0]  grant;
  logic        m_ar_hs;
  logic        m_r_hs;
  logic        m_r_last;
  logic [8:0]  beats_left;
  logic        busy;
  logic        done;
  logic [1:0]  err;

  modport master (
    output req, req_len, m_ar_hs, m_r_hs, m_r_last,
    input  grant, beats_left, busy, done, err
  );

  modport slave (
    input  req, req_len, m_ar_hs, m_r_hs, m_r_last,
    output grant, beats_left, busy, done, err
  );
endinterface

// File: rtl/rr_arb_2.sv
// Two-way round-robin decision: a sole requester wins, a tie goes to the
// requester that was not granted last. Purely combinational.
module rr_arb_2 (
  input  logic [1:0] req,
  input  logic       last,   // 1: s01 was granted last, 0: s00 was
  output logic [1:0] grant
);

  always_comb begin
    // NOTE: default first so every path assigns grant and no latch is inferred.
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/axi_rd_sched_2x1.sv
// Schedules read bursts from two requesters onto one AXI master read port,
// tracking R beats and flagging rlast mismatches and handshake timeouts.
module axi_rd_sched_2x1
  import axi_sched_pkg::*;
#(
  parameter int ID_WIDTH       = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [15:0] req_len,
  output logic [1:0]  grant,
  input  logic        m_ar_hs,
  input  logic        m_r_hs,
  input  logic        m_r_last,
  output logic [8:0]  beats_left,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535 || ID_WIDTH < 1) begin : g_param_check
    $error("axi_rd_sched_2x1: illegal parameter value");
  end

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state;
  logic        last_s01;
  logic [15:0] tcnt;
  logic [1:0]  arb_grant;
  logic        to_hit;
  logic        last_beat;
  logic [8:0]  load_beats;

  rr_arb_2 u_arb (
    .req   (req),
    .last  (last_s01),
    .grant (arb_grant)
  );

  // Timeout fires on the edge where the idle count would reach TIMEOUT_CYCLES-1.
  assign to_hit     = (tcnt + 16'd1) == TO_LAST;
  assign last_beat  = beats_left == 9'd1;
  assign load_beats = beats_of(grant[1] ? req_len[15:8] : req_len[7:0]);

  // NOTE: all state and outputs use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 2'b00;
      beats_left <= 9'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 2'b00;
      tcnt       <= 16'd0;
      last_s01   <= 1'b1;
    end else begin
      done <= 1'b0;
      err  <= 2'b00;
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            state    <= ADDR;
            grant    <= arb_grant;
            last_s01 <= arb_grant[1];
            busy     <= 1'b1;
            tcnt     <= 16'd0;
          end
        end
        ADDR: begin
          if (m_ar_hs) begin
            beats_left <= load_beats;
            state      <= DATA;
            tcnt       <= 16'd0;
          end else if (to_hit) begin
            err[ERR_TIMEOUT] <= 1'b1;
            beats_left       <= 9'd0;
            state            <= IDLE;
            grant            <= 2'b00;
            busy             <= 1'b0;
            tcnt             <= 16'd0;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        DATA: begin
          if (m_r_hs) begin
            tcnt <= 16'd0;
            if (m_r_last && last_beat) begin
              done       <= 1'b1;
              beats_left <= 9'd0;
              state      <= IDLE;
              grant      <= 2'b00;
              busy       <= 1'b0;
            end else if (m_r_last || last_beat) begin
              // rlast disagrees with the beat count; this path wins over timeout.
              err[ERR_RLAST] <= 1'b1;
              beats_left     <= 9'd0;
              state          <= IDLE;
              grant          <= 2'b00;
              busy           <= 1'b0;
            end else begin
              beats_left <= beats_left - 9'd1;
            end
          end else if (to_hit) begin
            err[ERR_TIMEOUT] <= 1'b1;
            beats_left       <= 9'd0;
            state            <= IDLE;
            grant            <= 2'b00;
            busy             <= 1'b0;
            tcnt             <= 16'd0;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_sched_2x1.sv
// Directed bench for axi_rd_sched_2x1: arbitration order, beat counting,
// rlast errors, timeouts and mid-burst reset, with hand-computed expectations.
module tb_axi_rd_sched_2x1;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  axi_rd_sched_2x1_if bus ();

  axi_rd_sched_2x1 #(.ID_WIDTH(8), .TIMEOUT_CYCLES(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (bus.req),
    .req_len    (bus.req_len),
    .grant      (bus.grant),
    .m_ar_hs    (bus.m_ar_hs),
    .m_r_hs     (bus.m_r_hs),
    .m_r_last   (bus.m_r_last),
    .beats_left (bus.beats_left),
    .busy       (bus.busy),
    .done       (bus.done),
    .err        (bus.err)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = 2'b11; bus.req_len = 16'h0000;
    bus.m_ar_hs = 1'b0; bus.m_r_hs = 1'b0; bus.m_r_last = 1'b0;
    tick(3);
    n_cmp++; if (bus.grant !== 2'b00) begin n_bad++; $display("FAIL reset_grant: got %b want 00", bus.grant); end
    n_cmp++; if (bus.beats_left !== 9'd0) begin n_bad++; $display("FAIL reset_beats: got %0d want 0", bus.beats_left); end
    n_cmp++; if ({bus.busy, bus.done, bus.err} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags: got busy/done/err=%b want 0000", {bus.busy, bus.done, bus.err}); end
    bus.req = 2'b00;
    rst = 1'b0;
    tick();
    n_cmp++; if (bus.grant !== 2'b00) begin n_bad++; $display("FAIL idle_no_req: got %b want 00", bus.grant); end
  endtask

  task automatic test_round_robin();
    bus.req = 2'b11;
    tick();
    n_cmp++; if (bus.grant !== 2'b01) begin n_bad++; $display("FAIL rr_first: got %b want 01", bus.grant); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL rr_busy: got %b want 1", bus.busy); end
    bus.req_len = {8'd1, 8'd0};
    bus.m_ar_hs = 1'b1; tick(); bus.m_ar_hs = 1'b0;
    n_cmp++; if (bus.beats_left !== 9'd1) begin n_bad++; $display("FAIL rr_s0_beats: got %0d want 1", bus.beats_left); end
    bus.m_r_hs = 1'b1; bus.m_r_last = 1'b1; tick(); bus.m_r_hs = 1'b0; bus.m_r_last = 1'b0;
    n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL rr_s0_done: got %b want 1", bus.done); end
    n_cmp++; if (bus.grant !== 2'b00) begin n_bad++; $display("FAIL rr_idle_gap: got %b want 00", bus.grant); end
    tick();
    n_cmp++; if (bus.grant !== 2'b10) begin n_bad++; $display("FAIL rr_second: got %b want 10", bus.grant); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL rr_done_pulse: got %b want 0", bus.done); end
    bus.m_ar_hs = 1'b1; tick(); bus.m_ar_hs = 1'b0;
    n_cmp++; if (bus.beats_left !== 9'd2) begin n_bad++; $display("FAIL rr_s1_beats: got %0d want 2", bus.beats_left); end
    bus.m_r_hs = 1'b1; tick();
    n_cmp++; if (bus.beats_left !== 9'd1) begin n_bad++; $display("FAIL rr_s1_dec: got %0d want 1", bus.beats_left); end
    bus.m_r_last = 1'b1; bus.req = 2'b00; tick(); bus.m_r_hs = 1'b0; bus.m_r_last = 1'b0;
    n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL rr_s1_done: got %b want 1", bus.done); end
    tick();
    n_cmp++; if ({bus.grant, bus.busy} !== 3'b000) begin n_bad++; $display("FAIL rr_quiet: got grant/busy=%b want 000", {bus.grant, bus.busy}); end
  endtask

  task automatic test_burst_len();
    bus.req = 2'b01; bus.req_len = {8'd0, 8'd3};
    tick();
    n_cmp++; if (bus.grant !== 2'b01) begin n_bad++; $display("FAIL len_grant: got %b want 01", bus.grant); end
    bus.m_r_hs = 1'b1; bus.m_r_last = 1'b1; tick(); bus.m_r_hs = 1'b0; bus.m_r_last = 1'b0;
    n_cmp++; if ({bus.grant, bus.done, bus.err, bus.beats_left} !== {2'b01, 1'b0, 2'b00, 9'd0}) begin
      n_bad++; $display("FAIL addr_ignores_r: got grant=%b done=%b err=%b beats=%0d want 01/0/00/0", bus.grant, bus.done, bus.err, bus.beats_left);
    end
    bus.req = 2'b00;
    bus.m_ar_hs = 1'b1; tick(); bus.m_ar_hs = 1'b0;
    n_cmp++; if (bus.beats_left !== 9'd4) begin n_bad++; $display("FAIL len_load: got %0d want 4", bus.beats_left); end
    n_cmp++; if (bus.grant !== 2'b01) begin n_bad++; $display("FAIL len_grant_held: got %b want 01", bus.grant); end
    for (int i = 0; i < 4; i++) begin
      bus.m_r_hs = 1'b1; bus.m_r_last = (i == 3);
      tick();
      n_cmp++; if (bus.beats_left !== 9'(3 - i)) begin n_bad++; $display("FAIL len_beat%0d: got %0d want %0d", i, bus.beats_left, 3 - i); end
      n_cmp++; if (bus.done !== (i == 3)) begin n_bad++; $display("FAIL len_done%0d: got %b want %b", i, bus.done, i == 3); end
    end
    bus.m_r_hs = 1'b0; bus.m_r_last = 1'b0;
    n_cmp++; if ({bus.busy, bus.grant} !== 3'b000) begin n_bad++; $display("FAIL len_end: got busy/grant=%b want 000", {bus.busy, bus.grant}); end
    tick();
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL len_done_pulse: got %b want 0", bus.done); end
  endtask

  task automatic test_rlast_error();
    bus.req = 2'b10; bus.req_len = 16'h0000;
    tick();
    n_cmp++; if (bus.grant !== 2'b10) begin n_bad++; $display("FAIL rl_grant: got %b want 10", bus.grant); end
    bus.req = 2'b00;
    bus.m_ar_hs = 1'b1; tick(); bus.m_ar_hs = 1'b0;
    n_cmp++; if (bus.beats_left !== 9'd1) begin n_bad++; $display("FAIL rl_beats: got %0d want 1", bus.beats_left); end
    bus.m_r_hs = 1'b1; tick(); bus.m_r_hs = 1'b0;
    n_cmp++; if ({bus.err, bus.done, bus.grant, bus.busy, bus.beats_left} !== {2'b01, 1'b0, 2'b00, 1'b0, 9'd0}) begin
      n_bad++; $display("FAIL rl_missing_last: got err=%b done=%b grant=%b busy=%b beats=%0d want 01/0/00/0/0", bus.err, bus.done, bus.grant, bus.busy, bus.beats_left);
    end
    tick();
    n_cmp++; if (bus.err !== 2'b00) begin n_bad++; $display("FAIL rl_err_pulse: got %b want 00", bus.err); end
    bus.req = 2'b01; bus.req_len = {8'd0, 8'd2};
    tick();
    bus.req = 2'b00;
    bus.m_ar_hs = 1'b1; tick(); bus.m_ar_hs = 1'b0;
    n_cmp++; if (bus.beats_left !== 9'd3) begin n_bad++; $display("FAIL rl_early_beats: got %0d want 3", bus.beats_left); end
    bus.m_r_hs = 1'b1; bus.m_r_last = 1'b1; tick(); bus.m_r_hs = 1'b0; bus.m_r_last = 1'b0;
    n_cmp++; if ({bus.err, bus.done, bus.beats_left} !== {2'b01, 1'b0, 9'd0}) begin
      n_bad++; $display("FAIL rl_early_last: got err=%b done=%b beats=%0d want 01/0/0", bus.err, bus.done, bus.beats_left);
    end
    tick();
  endtask

  task automatic test_timeout();
    bus.req = 2'b01;
    tick();
    n_cmp++; if (bus.grant !== 2'b01) begin n_bad++; $display("FAIL to_grant: got %b want 01", bus.grant); end
    bus.req = 2'b00;
    for (int k = 2; k <= 7; k++) begin
      tick();
      n_cmp++; if ({bus.err, bus.grant} !== 4'b0001) begin n_bad++; $display("FAIL to_wait%0d: got err/grant=%b want 0001", k, {bus.err, bus.grant}); end
    end
    tick();
    n_cmp++; if ({bus.err, bus.grant, bus.busy} !== 5'b10000) begin n_bad++; $display("FAIL to_addr: got err/grant/busy=%b want 10000", {bus.err, bus.grant, bus.busy}); end
    tick();
    n_cmp++; if (bus.err !== 2'b00) begin n_bad++; $display("FAIL to_pulse: got %b want 00", bus.err); end
    bus.req = 2'b10; bus.req_len = {8'd3, 8'd0};
    tick();
    n_cmp++; if (bus.grant !== 2'b10) begin n_bad++; $display("FAIL tod_grant: got %b want 10", bus.grant); end
    bus.req = 2'b00;
    tick(4);
    bus.m_ar_hs = 1'b1; tick(); bus.m_ar_hs = 1'b0;
    n_cmp++; if (bus.beats_left !== 9'd4) begin n_bad++; $display("FAIL tod_beats: got %0d want 4", bus.beats_left); end
    tick(6);
    n_cmp++; if ({bus.err, bus.beats_left} !== {2'b00, 9'd4}) begin n_bad++; $display("FAIL tod_wait1: got err=%b beats=%0d want 00/4", bus.err, bus.beats_left); end
    bus.m_r_hs = 1'b1; tick(); bus.m_r_hs = 1'b0;
    n_cmp++; if (bus.beats_left !== 9'd3) begin n_bad++; $display("FAIL tod_beat: got %0d want 3", bus.beats_left); end
    tick(6);
    n_cmp++; if (bus.err !== 2'b00) begin n_bad++; $display("FAIL tod_wait2: got %b want 00", bus.err); end
    tick();
    n_cmp++; if ({bus.err, bus.grant, bus.beats_left} !== {2'b10, 2'b00, 9'd0}) begin
      n_bad++; $display("FAIL tod_fire: got err=%b grant=%b beats=%0d want 10/00/0", bus.err, bus.grant, bus.beats_left);
    end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    bus.req = 2'b01; bus.req_len = {8'd0, 8'd4};
    tick();
    bus.req = 2'b00;
    bus.m_ar_hs = 1'b1; tick(); bus.m_ar_hs = 1'b0;
    n_cmp++; if (bus.beats_left !== 9'd5) begin n_bad++; $display("FAIL mid_beats: got %0d want 5", bus.beats_left); end
    rst = 1'b1;
    tick();
    n_cmp++; if ({bus.grant, bus.beats_left, bus.busy, bus.done, bus.err} !== 15'd0) begin
      n_bad++; $display("FAIL mid_reset: got grant=%b beats=%0d busy=%b done=%b err=%b want all 0", bus.grant, bus.beats_left, bus.busy, bus.done, bus.err);
    end
    rst = 1'b0; bus.req = 2'b11;
    tick();
    n_cmp++; if (bus.grant !== 2'b01) begin n_bad++; $display("FAIL mid_rr_restart: got %b want 01", bus.grant); end
    bus.req = 2'b00;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_burst_len();
    test_rlast_error();
    test_timeout();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
